xoshiro256ss_gen: RTL and testbench
===================================

// Module: xoshiro256ss_gen
// PURPOSE
//  Sequential xoshiro256** PRNG that consumes the combinational Splitmix stage. On a seed request it
//  instantiates Splitmix and iterates it 4 times, one word per cycle, to fill the 256-bit state.
//  It then streams one 64-bit random word per valid/ready handshake.
//  Sits directly downstream of Splitmix; feeds consumers of random words.
// PARAMETERS
//  AUTO_SEED     1       1: seed from DEFAULT_SEED on the first cycle after reset release; 0: wait in IDLE
//  DEFAULT_SEED  64'h0   seed used when AUTO_SEED=1
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  rst_n       in   1   synchronous reset, active low
//  seed_valid  in   1   request (re)seed; sampled every cycle, always accepted
//  seed        in   64  seed value, sampled when seed_valid=1
//  busy        out  1   1 while seeding is in progress
//  out_valid   out  1   random word available
//  out_ready   in   1   consumer accepts out_value when out_valid & out_ready
//  out_value   out  64  xoshiro256** result of current state
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FSM=IDLE; s0..s3=0; Splitmix state register sm=0; idx=0; busy=0; out_valid=0.
//  out_value is a function of s0..s3 and holds the all-zero-state result (0) while out_valid=0.
//  FSM states: IDLE, SEED, RUN.
//   IDLE: out_valid=0, busy=0. seed_valid -> sm<=seed, idx<=0, go SEED.
//         If AUTO_SEED=1, the first post-reset cycle acts as seed_valid with DEFAULT_SEED.
//   SEED: busy=1, out_valid=0. Each cycle: s[idx]<=Splitmix(sm).value; sm<=Splitmix(sm).next_state; idx++.
//         After writing s3 (idx=3), go RUN. Exactly 4 SEED cycles.
//   RUN: out_valid=1, busy=0. On out_valid&out_ready, advance state in one cycle
//        (all 64-bit, mod 2^64; rotl = rotate left):
//         t=s1<<17; s2'=s2^s0; s3'=s3^s1; s1'=s1^s2'; s0'=s0^s3'; s2''=s2'^t; s3''=rotl(s3',45).
//  Output function: out_value = rotl(s1*5, 7) * 9, truncated to 64 bits.
//  Timing: seed sampled at edge E0; s0..s3 written at E1..E4; busy=1 after E0 through E4;
//   out_valid=1 after E4. First word is available 5 edges after seed acceptance.
//  Throughput: one word per cycle while out_ready held high.
//  Stall: when out_valid=1 and out_ready=0, s0..s3 and out_value are held stable.
//  seed_valid during SEED or RUN (priority over out_ready):
//   - seeding restarts from the new seed: sm<=seed, idx<=0, state=SEED.
//   - out_valid drops on the following cycle.
//   - a handshake in that same cycle is ignored; no state advance.
//  Reset mid-SEED or mid-RUN: return to reset values; a partially written state is discarded.
//  Splitmix is purely combinational; its inputs are driven only from sm, never from external ports.
// TESTING
//  1 AUTO_SEED=0, seed=0:
//    s0..s3 = e220a8397b1dcdaf, 6e789e6aa1b965f4, 06c45d188009454f, f88bb8a8724c81ec;
//    out_valid rises exactly 5 edges after seed_valid; busy high 4 cycles.
//  2 seed=0, out_ready=1 for 1000 cycles:
//    out_value sequence matches the C reference model (splitmix64 seeding + xoshiro256**) word-for-word.
//  3 Stall: out_ready toggled pseudo-randomly:
//    out_value stable while out_ready=0; accepted-word sequence identical to test 2.
//  4 Reseed mid-SEED (idx=2) with seed=0x1234 and mid-RUN with seed=0:
//    streams restart and match the reference model for the new seed; no stale word accepted.
//  5 Reset: rst_n low during SEED and during RUN -> next cycle out_valid=0, busy=0, out_value=0.
//    AUTO_SEED=1, DEFAULT_SEED=0 -> after release, first word equals test 2's first word.
//  6 Splitmix hookup: seed=64'hffffffffffffffff -> sm wraps modulo 2^64;
//    state words match the reference model.

Source files
------------

// File: rtl/xoshiro256ss_gen_if.sv
// Seed request and random-word stream bundle for xoshiro256ss_gen.
// The slave side is the generator; the master side seeds it and consumes words.
interface xoshiro256ss_gen_if;
  logic        seed_valid;
  logic [63:0] seed;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;

  modport master (
    output seed_valid, seed, out_ready,
    input  busy, out_valid, out_value
  );

  modport slave (
    input  seed_valid, seed, out_ready,
    output busy, out_valid, out_value
  );
endinterface

// File: rtl/xoshiro256ss_gen.sv
// xoshiro256** generator seeded by four iterations of a combinational splitmix64 stage,
// streaming one 64-bit word per valid/ready handshake.
module xoshiro256ss_splitmix64 (
  input  logic [63:0] i_state,
  output logic [63:0] o_value,
  output logic [63:0] o_next
);
  localparam logic [63:0] GAMMA = 64'h9e3779b97f4a7c15;
  localparam logic [63:0] MIX1  = 64'hbf58476d1ce4e5b9;
  localparam logic [63:0] MIX2  = 64'h94d049bb133111eb;

  logic [63:0] w_z1;
  logic [63:0] w_z2;

  assign o_next  = i_state + GAMMA;
  assign w_z1    = (o_next ^ (o_next >> 30)) * MIX1;
  assign w_z2    = (w_z1 ^ (w_z1 >> 27)) * MIX2;
  assign o_value = w_z2 ^ (w_z2 >> 31);
endmodule

module xoshiro256ss_gen #(
  parameter bit          AUTO_SEED    = 1'b1,
  parameter logic [63:0] DEFAULT_SEED = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  xoshiro256ss_gen_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_RUN} state_t;

  state_t      r_state;
  logic [63:0] r_s [4];
  logic [63:0] r_sm;
  logic [1:0]  r_idx;
  logic        r_busy;
  logic        r_out_valid;
  logic        r_auto;

  logic [63:0] w_sm_value;
  logic [63:0] w_sm_next;
  logic        w_start;
  logic [63:0] w_start_seed;
  logic [63:0] w_s1x5;
  logic [63:0] w_rot7;
  logic [63:0] w_result;
  logic [63:0] w_t;
  logic [63:0] w_s2a;
  logic [63:0] w_s3a;
  logic [63:0] w_n0;
  logic [63:0] w_n1;
  logic [63:0] w_n2;
  logic [63:0] w_n3;

  // Splitmix sees only the internal state register, never the seed port.
  xoshiro256ss_splitmix64 u_splitmix (
    .i_state (r_sm),
    .o_value (w_sm_value),
    .o_next  (w_sm_next)
  );

  // r_auto is set only during the first cycle after reset, while the FSM is still IDLE.
  assign w_start      = bus.seed_valid | r_auto;
  assign w_start_seed = bus.seed_valid ? bus.seed : DEFAULT_SEED;

  assign w_s1x5   = r_s[1] * 64'd5;
  assign w_rot7   = {w_s1x5[56:0], w_s1x5[63:57]};
  assign w_result = w_rot7 * 64'd9;

  assign w_t   = r_s[1] << 17;
  assign w_s2a = r_s[2] ^ r_s[0];
  assign w_s3a = r_s[3] ^ r_s[1];
  assign w_n1  = r_s[1] ^ w_s2a;
  assign w_n0  = r_s[0] ^ w_s3a;
  assign w_n2  = w_s2a ^ w_t;
  assign w_n3  = {w_s3a[18:0], w_s3a[63:19]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) r_s[i] <= '0;
      r_sm        <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_auto      <= AUTO_SEED;
    end else begin
      r_auto <= 1'b0;
      if (w_start) begin
        // A seed request outranks any handshake in the same cycle.
        r_sm        <= w_start_seed;
        r_idx       <= '0;
        r_state     <= ST_SEED;
        r_busy      <= 1'b1;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
          ST_SEED: begin
            r_s[r_idx] <= w_sm_value;
            r_sm       <= w_sm_next;
            r_idx      <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state     <= ST_RUN;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
          ST_RUN: begin
            if (r_out_valid && bus.out_ready) begin
              r_s[0] <= w_n0;
              r_s[1] <= w_n1;
              r_s[2] <= w_n2;
              r_s[3] <= w_n3;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  // Partially seeded or stale state never leaks onto the output.
  assign bus.out_value = r_out_valid ? w_result : 64'd0;
endmodule

// File: tb/tb_xoshiro256ss_gen.sv
// Scoreboard bench for xoshiro256ss_gen: a reference splitmix64/xoshiro256** model
// predicts every accepted word, plus timing, stall, reseed and reset checks.
module tb_xoshiro256ss_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xoshiro256ss_gen_if bus();
  xoshiro256ss_gen_if bus_a();

  xoshiro256ss_gen #(.AUTO_SEED(1'b0), .DEFAULT_SEED(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  xoshiro256ss_gen #(.AUTO_SEED(1'b1), .DEFAULT_SEED(64'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  logic [63:0] m_s [4];
  logic [63:0] exp_q [$];
  bit          hold_v = 1'b0;
  logic [63:0] hold_val;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int k);
    return (x << k) | (x >> (64 - k));
  endfunction

  task automatic model_seed(input logic [63:0] sd);
    logic [63:0] x, z;
    x = sd;
    for (int i = 0; i < 4; i++) begin
      x = x + 64'h9e3779b97f4a7c15;
      z = x;
      z = (z ^ (z >> 30)) * 64'hbf58476d1ce4e5b9;
      z = (z ^ (z >> 27)) * 64'h94d049bb133111eb;
      m_s[i] = z ^ (z >> 31);
    end
  endtask

  task automatic model_next(output logic [63:0] r);
    logic [63:0] t;
    r = rotl(m_s[1] * 64'd5, 7) * 64'd9;
    t = m_s[1] << 17;
    m_s[2] = m_s[2] ^ m_s[0];
    m_s[3] = m_s[3] ^ m_s[1];
    m_s[1] = m_s[1] ^ m_s[2];
    m_s[0] = m_s[0] ^ m_s[3];
    m_s[2] = m_s[2] ^ t;
    m_s[3] = rotl(m_s[3], 45);
  endtask

  // Called just after a falling edge; drives one cycle of stimulus and advances to the next falling edge.
  task automatic step(input logic sv, input logic [63:0] sd, input logic rdy);
    logic [63:0] e;
    if (hold_v) begin
      check64("stall_hold", bus.out_value, hold_val);
      hold_v = 1'b0;
    end
    bus.seed_valid = sv;
    bus.seed       = sd;
    bus.out_ready  = rdy;
    if (sv) begin
      model_seed(sd);
      exp_q.delete();
    end else if (bus.out_valid && rdy) begin
      model_next(e);
      exp_q.push_back(e);
    end else if (bus.out_valid) begin
      hold_v   = 1'b1;
      hold_val = bus.out_value;
    end
    if (!sv && bus.out_valid && rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check64("word", bus.out_value, e);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n          = 1'b0;
    bus.seed_valid = 1'b0;
    hold_v         = 1'b0;
    @(negedge clk);
    check64({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check64({tag, "_busy"},  {63'd0, bus.busy},      64'd0);
    check64({tag, "_value"}, bus.out_value,          64'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_auto();
    int k;
    logic [63:0] e;
    k = 0;
    while (!bus_a.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check64("auto_valid", {63'd0, bus_a.out_valid}, 64'd1);
    model_seed(64'd0);
    model_next(e);
    check64("auto_first", bus_a.out_value, e);
  endtask

  initial begin
    bus.seed_valid   = 1'b0;
    bus.seed         = 64'd0;
    bus.out_ready    = 1'b0;
    bus_a.seed_valid = 1'b0;
    bus_a.seed       = 64'd0;
    bus_a.out_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check64("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check64("rst_busy",  {63'd0, bus.busy},      64'd0);
    check64("rst_value", bus.out_value,          64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check64("idle_valid", {63'd0, bus.out_valid}, 64'd0);
    wait_auto();

    // Seed 0: busy for exactly four cycles, valid after the fifth edge.
    step(1'b1, 64'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check64("t1_busy",  {63'd0, bus.busy},      64'd1);
      check64("t1_valid", {63'd0, bus.out_valid}, 64'd0);
      step(1'b0, 64'd0, 1'b0);
    end
    check64("t1_busy_end",  {63'd0, bus.busy},      64'd0);
    check64("t1_valid_end", {63'd0, bus.out_valid}, 64'd1);
    check64("t1_s0", dut.r_s[0], 64'he220a8397b1dcdaf);
    check64("t1_s1", dut.r_s[1], 64'h6e789e6aa1b965f4);
    check64("t1_s2", dut.r_s[2], 64'h06c45d188009454f);
    check64("t1_s3", dut.r_s[3], 64'hf88bb8a8724c81ec);

    n_acc = 0;
    repeat (1000) step(1'b0, 64'd0, 1'b1);
    check64("t2_count", 64'(n_acc), 64'd1000);

    // Same stream under random backpressure.
    step(1'b1, 64'd0, 1'b0);
    n_acc = 0;
    repeat (800) step(1'b0, 64'd0, 1'($urandom_range(0, 1)));
    check64("t3_some", {63'd0, n_acc > 100}, 64'd1);

    // Reseed with idx=2 mid-SEED, then again mid-RUN.
    step(1'b1, 64'd5, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    check64("t4_idx", {62'd0, dut.r_idx}, 64'd2);
    step(1'b1, 64'h1234, 1'b1);
    n_acc = 0;
    repeat (300) step(1'b0, 64'd0, 1'b1);
    check64("t4_count_a", 64'(n_acc), 64'd296);
    step(1'b1, 64'd0, 1'b1);
    check64("t4_drop_valid", {63'd0, bus.out_valid}, 64'd0);
    check64("t4_busy",       {63'd0, bus.busy},      64'd1);
    n_acc = 0;
    repeat (200) step(1'b0, 64'd0, 1'b1);
    check64("t4_count_b", 64'(n_acc), 64'd196);

    // Splitmix state wraps modulo 2^64.
    step(1'b1, 64'hffffffffffffffff, 1'b0);
    repeat (4) step(1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) check64("t6_state", dut.r_s[i], m_s[i]);
    repeat (20) step(1'b0, 64'd0, 1'b1);

    // Reset mid-SEED and mid-RUN.
    step(1'b1, 64'd7, 1'b0);
    step(1'b0, 64'd0, 1'b0);
    reset_and_check("t5_seed");
    step(1'b1, 64'd9, 1'b1);
    repeat (10) step(1'b0, 64'd0, 1'b1);
    reset_and_check("t5_run");
    wait_auto();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
